// File: rtl/fabric2_pkg.sv
// fabric2_pkg: OCP encodings, FSM state and grant types shared by the fabric v2 slave port.
package fabric2_pkg;
  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;
  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_RESP = 2'd2} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  function automatic logic is_req(input logic [2:0] cmd);
    return (cmd == OCP_CMD_READ) || (cmd == OCP_CMD_WRITE);
  endfunction
endpackage

// File: rtl/fabric2_rr_arb2.sv
// fabric2_rr_arb2: two-requester round-robin picker; on conflict the master not granted last wins.
module fabric2_rr_arb2
  import fabric2_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  gnt_t last_grant,
  output logic gnt_d
);
  assign gnt_d = req_d & (~req_i | (last_grant == GNT_I));
endmodule

// File: rtl/fabric2_slave_port.sv
// fabric2_slave_port: merges the I and D OCP masters onto one slave, returning each response to its issuer.
module fabric2_slave_port
  import fabric2_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_I_MAddr,
  input  logic [2:0]            i_I_MCmd,
  input  logic [DATA_WIDTH-1:0] i_I_MData,
  input  logic [BE_WIDTH-1:0]   i_I_MByteEn,
  output logic                  o_I_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_I_SData,
  output logic [1:0]            o_I_SResp,
  input  logic [ADDR_WIDTH-1:0] i_D_MAddr,
  input  logic [2:0]            i_D_MCmd,
  input  logic [DATA_WIDTH-1:0] i_D_MData,
  input  logic [BE_WIDTH-1:0]   i_D_MByteEn,
  output logic                  o_D_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_D_SData,
  output logic [1:0]            o_D_SResp,
  output logic [ADDR_WIDTH-1:0] o_S_MAddr,
  output logic [2:0]            o_S_MCmd,
  output logic [DATA_WIDTH-1:0] o_S_MData,
  output logic [BE_WIDTH-1:0]   o_S_MByteEn,
  input  logic                  i_S_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_S_SData,
  input  logic [1:0]            i_S_SResp
);
  state_t state, state_nx;
  gnt_t   gnt, last_grant;
  logic   req_i, req_d, gnt_d;
  logic   sel_d, in_cmd, acc, fwd, has_resp;
  assign req_i = is_req(i_I_MCmd);
  assign req_d = is_req(i_D_MCmd);
  fabric2_rr_arb2 u_arb (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .gnt_d      (gnt_d)
  );
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= ST_IDLE;
      gnt        <= GNT_I;
      last_grant <= GNT_I;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) gnt <= gnt_d ? GNT_D : GNT_I;
      if (acc) last_grant <= gnt;
    end
  end
  // The response path is open in RESP, and in CMD only on the accept cycle so a same-cycle reply reaches the master.
  always_comb begin
    sel_d    = (gnt == GNT_D);
    in_cmd   = (state == ST_CMD);
    acc      = in_cmd & i_S_SCmdAccept;
    fwd      = (state == ST_RESP) | acc;
    has_resp = (i_S_SResp != OCP_RESP_NULL);
    state_nx = (state == ST_IDLE) ? ((req_i | req_d) ? ST_CMD : ST_IDLE) :
               (state == ST_CMD)  ? (i_S_SCmdAccept ? (has_resp ? ST_IDLE : ST_RESP) : ST_CMD) :
               (state == ST_RESP) ? (has_resp ? ST_IDLE : ST_RESP) : ST_IDLE;
    o_S_MCmd       = in_cmd ? (sel_d ? i_D_MCmd    : i_I_MCmd)    : OCP_CMD_IDLE;
    o_S_MAddr      = in_cmd ? (sel_d ? i_D_MAddr   : i_I_MAddr)   : '0;
    o_S_MData      = in_cmd ? (sel_d ? i_D_MData   : i_I_MData)   : '0;
    o_S_MByteEn    = in_cmd ? (sel_d ? i_D_MByteEn : i_I_MByteEn) : '0;
    o_I_SCmdAccept = acc & ~sel_d;
    o_D_SCmdAccept = acc & sel_d;
    o_I_SResp      = (fwd & ~sel_d) ? i_S_SResp : OCP_RESP_NULL;
    o_D_SResp      = (fwd &  sel_d) ? i_S_SResp : OCP_RESP_NULL;
    o_I_SData      = (fwd & ~sel_d) ? i_S_SData : '0;
    o_D_SData      = (fwd &  sel_d) ? i_S_SData : '0;
  end
endmodule
